// File: rtl/seq_det_scheduler_pkg.sv
// rtl/seq_det_scheduler_pkg.sv - FSM encoding and pattern constants for the serial detector sequencer
package seq_det_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam int PAT_LEN = 3;
  localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;

  function automatic logic pat_match(input logic [PAT_LEN-2:0] hist, input logic bit_in);
    return {hist, bit_in} == PATTERN;
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// rtl/seq_det_scheduler_if.sv - word-in / count-out handshake bundle of the detector sequencer
interface seq_det_scheduler_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
);
  import seq_det_scheduler_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_any;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_any
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_any
  );

endinterface

// File: rtl/seq_det_scheduler_bit_pattern_det.sv
// rtl/seq_det_scheduler_bit_pattern_det.sv - serial overlapping "101" detector with registered hit flag
module bit_pattern_det
  import seq_det_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic hit
);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic               hit_q, hit_d;

  // hit is a one-cycle pulse per matching bit; it drops whenever no bit is presented
  always_comb begin
    hist_d = hist_q;
    hit_d  = 1'b0;
    if (clr) begin
      hist_d = '0;
    end else if (bit_vld) begin
      hist_d = {hist_q[PAT_LEN-3:0], bit_in};
      hit_d  = pat_match(hist_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      hit_q  <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - accepts words, feeds them MSB-first to the serial detector, reports hit counts
module seq_det_scheduler
  import seq_det_scheduler_pkg::*;
#(
  parameter int W          = 8,
  parameter int CW         = $clog2(W + 1),
  parameter bit CARRY_HIST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_det_scheduler_if.slave   bus,
  output logic                 busy
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]  hit_cnt_q, hit_cnt_d;

  logic accept;
  logic det_clr;
  logic bit_vld;
  logic det_hit;

  assign accept  = bus.in_valid && bus.in_ready;
  assign det_clr = accept && !CARRY_HIST;

  bit_pattern_det u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (det_clr),
    .bit_vld (bit_vld),
    .bit_in  (sreg_q[W-1]),
    .hit     (det_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SHIFT;
      ST_SHIFT:  if (bit_cnt_q == LAST_BIT) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_REPORT;
      ST_REPORT: if (bus.out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && !rst;
    bus.out_valid = (state_q == ST_REPORT);
    bus.out_count = (state_q == ST_REPORT) ? hit_cnt_q : '0;
    bus.out_any   = (state_q == ST_REPORT) && (hit_cnt_q != '0);
    busy          = (state_q != ST_IDLE);
    bit_vld       = (state_q == ST_SHIFT);
  end

  // The flag seen in SHIFT/DRAIN always belongs to a bit of the current word:
  // it is registered one cycle behind its bit and falls back to 0 outside SHIFT.
  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    hit_cnt_d = hit_cnt_q;
    if (accept) begin
      sreg_d    = bus.in_data;
      bit_cnt_d = '0;
      hit_cnt_d = '0;
    end
    if (state_q == ST_SHIFT) begin
      sreg_d    = {sreg_q[W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && det_hit) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb/tb_seq_det_scheduler.sv - scoreboard bench for seq_det_scheduler with and without history carry
module tb_seq_det_scheduler;

  localparam int W   = 8;
  localparam int LAT = W + 2;
  localparam int GAP = W + 3;

  logic clk;
  logic rst;
  logic busy_c, busy_n;

  seq_det_scheduler_if #(.W(W)) bus_c ();
  seq_det_scheduler_if #(.W(W)) bus_n ();

  seq_det_scheduler #(.W(W), .CARRY_HIST(1'b1)) dut_c (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_c.slave),
    .busy (busy_c)
  );

  seq_det_scheduler #(.W(W), .CARRY_HIST(1'b0)) dut_n (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_n.slave),
    .busy (busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_c  = 0;
  int acc_n  = 0;
  int exp_c[$];
  int exp_n[$];
  bit pv_c   = 1'b0;
  bit pv_n   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every result handshake pops the oldest expected count
  always @(negedge clk) begin
    int e;
    if (rst) begin
      pv_c = 1'b0;
    end else begin
      if (bus_c.out_valid && !pv_c) chk("latency_c", cyc - acc_c, LAT);
      if (bus_c.out_valid && bus_c.out_ready) begin
        if (exp_c.size() == 0) begin
          chk("unexpected_result_c", 1, 0);
        end else begin
          e = exp_c.pop_front();
          chk("count_c", int'(bus_c.out_count), e);
          chk("any_c", int'(bus_c.out_any), int'(e != 0));
        end
      end
      pv_c = bus_c.out_valid;
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst) begin
      pv_n = 1'b0;
    end else begin
      if (bus_n.out_valid && !pv_n) chk("latency_n", cyc - acc_n, LAT);
      if (bus_n.out_valid && bus_n.out_ready) begin
        if (exp_n.size() == 0) begin
          chk("unexpected_result_n", 1, 0);
        end else begin
          e = exp_n.pop_front();
          chk("count_n", int'(bus_n.out_count), e);
          chk("any_n", int'(bus_n.out_any), int'(e != 0));
        end
      end
      pv_n = bus_n.out_valid;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] w, input int exp, input bit hold,
                      output int acc);
    acc = -1;
    if (exp >= 0) begin
      if (sel) exp_n.push_back(exp);
      else     exp_c.push_back(exp);
    end
    if (sel) begin bus_n.in_valid = 1'b1; bus_n.in_data = w; end
    else     begin bus_c.in_valid = 1'b1; bus_c.in_data = w; end
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((sel ? bus_n.in_ready : bus_c.in_ready) == 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 1, 0);
    if (sel) acc_n = acc;
    else     acc_c = acc;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) bus_n.in_valid = 1'b0;
      else     bus_c.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit sel);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sel ? (exp_n.size() == 0 && bus_n.in_ready) : (exp_c.size() == 0 && bus_c.in_ready)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b_w [4] = '{8'hA5, 8'h55, 8'hFF, 8'h40};
  int         b2b_e [4] = '{2, 4, 0, 1};
  int         b2b_a [4];

  initial begin
    int a;
    bit seen;
    rst             = 1'b1;
    bus_c.in_valid  = 1'b0;
    bus_c.in_data   = '0;
    bus_c.out_ready = 1'b1;
    bus_n.in_valid  = 1'b0;
    bus_n.in_data   = '0;
    bus_n.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus_c.in_ready), 0);
    chk("rst_busy", int'(busy_c), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus_c.in_ready), 1);
    chk("post_rst_out_valid", int'(bus_c.out_valid), 0);
    chk("post_rst_out_count", int'(bus_c.out_count), 0);
    chk("post_rst_out_any", int'(bus_c.out_any), 0);
    chk("post_rst_busy", int'(busy_c), 0);
    @(posedge clk);
    #1;

    // Basic words; order keeps the carried history from adding boundary hits
    send(1'b0, 8'hAA, 3, 1'b0, a);
    send(1'b0, 8'h00, 0, 1'b0, a);
    send(1'b0, 8'hB5, 3, 1'b0, a);
    send(1'b0, 8'h00, 0, 1'b0, a);

    // Boundary-spanning hit: counted only with history carry
    send(1'b0, 8'h02, 0, 1'b0, a);
    send(1'b0, 8'h80, 1, 1'b0, a);
    send(1'b1, 8'h02, 0, 1'b0, a);
    send(1'b1, 8'h80, 0, 1'b0, a);
    wait_idle(1'b0);
    wait_idle(1'b1);

    // Downstream stall
    bus_c.out_ready = 1'b0;
    send(1'b0, 8'hB5, 3, 1'b0, a);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_c.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("stall_valid_timeout", 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_out_valid", int'(bus_c.out_valid), 1);
      chk("stall_out_count", int'(bus_c.out_count), 3);
      chk("stall_in_ready", int'(bus_c.in_ready), 0);
      chk("stall_busy", int'(busy_c), 1);
    end
    @(posedge clk);
    #1 bus_c.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", int'(bus_c.in_ready), 1);
    chk("release_busy", int'(busy_c), 0);
    chk("release_out_valid", int'(bus_c.out_valid), 0);
    @(posedge clk);
    #1;

    // Abort mid-word with reset
    send(1'b0, 8'hAA, -1, 1'b0, a);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_in_ready", int'(bus_c.in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", int'(bus_c.out_valid), 0);
    chk("abort_out_count", int'(bus_c.out_count), 0);
    chk("abort_out_any", int'(bus_c.out_any), 0);
    chk("abort_busy", int'(busy_c), 0);
    chk("abort_in_ready", int'(bus_c.in_ready), 1);
    @(posedge clk);
    #1;
    send(1'b0, 8'h05, 1, 1'b0, a);
    wait_idle(1'b0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) begin
      send(1'b0, b2b_w[i], b2b_e[i], 1'b1, b2b_a[i]);
    end
    bus_c.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("b2b_spacing", b2b_a[i] - b2b_a[i-1], GAP);
    end
    wait_idle(1'b0);
    wait_idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
